// File: rtl/corr_result_buffer.sv
// corr_result_buffer: ping-pong capture of correlator integrals with epoch stamps,
// exposed to the CPU through a registered read port and an explicit release handshake.
module corr_result_buffer #(
    parameter int NWORDS = 6,
    parameter int ADDR_W = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  epoch,
    input  logic                  flush,
    input  logic [16*NWORDS-1:0]  corr_in,
    input  logic                  rd_en,
    input  logic [ADDR_W-1:0]     rd_addr,
    input  logic                  rd_release,
    input  logic                  ovf_clr,
    output logic [15:0]           rd_data,
    output logic                  data_ready,
    output logic                  overflow
);
    typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} occ_t;
    occ_t occ, occ_nx;
    logic epoch_d, wr_ptr, rd_ptr, store, advance, drop;
    logic [15:0] epoch_cnt, word;
    logic [16*NWORDS-1:0] set_mem [2];
    logic [15:0] stamp_mem [2];
    always_comb begin
        occ_nx  = occ;
        store   = 1'b0;
        advance = 1'b0;
        drop    = 1'b0;
        case (occ)
            EMPTY: begin
                store  = epoch_d;
                occ_nx = epoch_d ? ONE : EMPTY;
            end
            ONE: begin
                store   = epoch_d;
                advance = rd_release;
                occ_nx  = (epoch_d && !rd_release) ? FULL : (!epoch_d && rd_release) ? EMPTY : ONE;
            end
            default: begin
                // a same-edge release frees the oldest slot, which is exactly where wr_ptr points
                store   = epoch_d && rd_release;
                advance = rd_release;
                drop    = epoch_d && !rd_release;
                occ_nx  = (rd_release && !epoch_d) ? ONE : FULL;
            end
        endcase
        if (flush) begin
            occ_nx  = EMPTY;
            store   = 1'b0;
            advance = 1'b0;
            drop    = 1'b0;
        end
    end
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) occ <= EMPTY;
        else occ <= occ_nx;
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            epoch_d   <= 1'b0;
            epoch_cnt <= 16'h0;
            wr_ptr    <= 1'b0;
            rd_ptr    <= 1'b0;
            overflow  <= 1'b0;
            rd_data   <= 16'h0;
        end else if (flush) begin
            epoch_d   <= 1'b0;
            epoch_cnt <= 16'h0;
            wr_ptr    <= 1'b0;
            rd_ptr    <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            epoch_d   <= epoch;
            epoch_cnt <= epoch_d ? epoch_cnt + 16'd1 : epoch_cnt;
            wr_ptr    <= wr_ptr ^ store;
            rd_ptr    <= rd_ptr ^ advance;
            overflow  <= drop | (overflow & ~ovf_clr);
            rd_data   <= rd_en ? word : rd_data;
        end
    always_ff @(posedge clk)
        if (store) begin
            set_mem[wr_ptr]   <= corr_in;
            stamp_mem[wr_ptr] <= epoch_cnt + 16'd1;
        end
    always_comb begin
        word = 16'h0;
        for (int j = 0; j < NWORDS; j++)
            if (rd_addr == ADDR_W'(j)) word = set_mem[rd_ptr][16*j +: 16];
        if (rd_addr == ADDR_W'(NWORDS)) word = stamp_mem[rd_ptr];
        if (rd_addr == ADDR_W'(NWORDS + 1)) word = {13'b0, overflow, occ};
    end
    assign data_ready = (occ != EMPTY);
endmodule
